router_input_unit: RTL and testbench
====================================

Name: router_input_unit

Overview:
- Leaf-router input port that terminates the link driven by a PE network interface.
- Buffers incoming 36-bit flits in a credit-managed FIFO and decodes the 4-bit packet-info field of the head flit into a per-output-port request vector.
- Holds each multicast head flit until every requested output port has taken it, then dequeues it and returns one credit upstream.
- Its credit output feeds the NI's downstream_credit input.

Parameters:
- FIFO_DEPTH, `ROUTER_FIFO_DEPTH` (4): flit slots. Must equal the upstream credit counter's reset value.
- NUM_PORTS, 5: router output ports. Ports 0..NUM_PORTS-2 are children (PEs); port NUM_PORTS-1 is the parent.
- PORT_ID, 0: index of the child port this unit receives from. It is excluded from the broadcast fan-out.

Ports:
- clk  input  1  system clock
- rst  input  1  system reset. Asynchronous, active-high.
- in_data_valid  input  1  flit valid from the upstream NI
- in_data  input  `ROUTER_WIDTH` (36)  flit: [35:32] info, [31:16] addr, [15:0] data
- upstream_credit  output  1  one-cycle pulse per dequeued flit
- sw_req  output  NUM_PORTS  per-port request for the head flit
- sw_grant  input  NUM_PORTS  per-port one-cycle pulse: port consumed the head this cycle
- head_data  output  36  current head flit, valid while sw_req is nonzero
- overflow_err  output  1  sticky: a write arrived while full with no dequeue
- drop_err  output  1  sticky: a head flit carried an undefined info code

Behaviour:
- Reset values (asynchronous, all zero):
  - FIFO pointers and occupancy count = 0.
  - served mask = 0.
  - upstream_credit, overflow_err, drop_err = 0.
  - FIFO storage is not reset; head_data is don't-care while empty.
- Write:
  - When in_data_valid=1, in_data is written at the clk edge.
  - The head becomes visible at the earliest on the following cycle, so write-to-request latency is 1 cycle.
- Route decode (combinational from the head flit, only while not empty):
  - `ROUTER_INFO_BROADCAST` or `ROUTER_INFO_FIN_BROADCAST`: route = all NUM_PORTS ones, with bit PORT_ID cleared.
  - `ROUTER_INFO_READ` or `ROUTER_INFO_FIN_COMP`: route = parent bit only.
  - Any other code: route = 0, the packet is marked invalid.
- Requests: sw_req = route & ~served & {NUM_PORTS{not empty}}.
- Grants:
  - A grant on a port whose sw_req bit is 0 is ignored.
  - served accumulates valid grants: served <= served | (sw_grant & sw_req).
- Dequeue condition: ((served | (sw_grant & sw_req)) & route) == route with route != 0.
- On dequeue:
  - The read pointer advances.
  - served is cleared to 0 at the same edge.
  - upstream_credit pulses for exactly one cycle, on the cycle after the dequeue edge (registered).
- Invalid head:
  - Dequeued on the first cycle it is at the head, with no requests issued.
  - upstream_credit is returned as for a normal dequeue.
  - drop_err is set and stays 1 until reset.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Write and dequeue in the same cycle:
  - Occupancy is unchanged.
  - Permitted when full: the write is accepted into the slot being freed.
  - Permitted when occupancy is 1: the new flit becomes the head next cycle with served=0.
- Write while full with no dequeue:
  - The flit is dropped and no state changes.
  - overflow_err is set sticky. This only occurs if the upstream credit protocol is violated.
- Empty: sw_req = 0 and sw_grant is ignored.
- Throughput: one flit per cycle when every requested port grants on the first request cycle.
- Reset mid-operation: all queued flits and partial served state are discarded, and no credits are returned for them. Upstream must reset concurrently.

Test Plan:
- Reset, then one READ flit from PORT_ID=0 (info=READ, addr 0x0123, data 0xBEEF).
  - Next cycle: sw_req=5'b10000, head_data matches the written flit.
  - Grant bit 4: FIFO empties, upstream_credit pulses 1 cycle later.
- BROADCAST flit with PORT_ID=2.
  - sw_req=5'b11011.
  - Grant ports 0 and 4 in cycle 1: sw_req=5'b01010.
  - Grant ports 1 and 3 in cycle 2: dequeue, exactly one credit pulse.
- Fill 4 flits with no grants.
  - Occupancy = 4, no credits returned.
  - 5th write with no grant: overflow_err=1, and the 4 original flits drain in order.
- Full FIFO with a grant completing the head and a write in the same cycle.
  - No overflow, occupancy stays 4.
  - The new flit emerges 4th.
- Head with undefined info code 4'hF.
  - sw_req stays 0 and the flit is dequeued the next cycle.
  - drop_err=1, one credit pulse, and the following valid flit is requested normally.
- Stream 8 FIN_COMP flits back-to-back with sw_grant[4] held high.
  - One dequeue per cycle, 8 credit pulses, occupancy never exceeds 1.

Source files
------------

// File: rtl/router_input_unit_if.sv
// Link bundle for the router input unit: upstream flit/credit pair plus the
// switch-side request/grant/head-data path.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef ROUTER_INFO_READ
`define ROUTER_INFO_READ 4'h1
`define ROUTER_INFO_FIN_COMP 4'h2
`define ROUTER_INFO_BROADCAST 4'h3
`define ROUTER_INFO_FIN_BROADCAST 4'h4
`endif

interface router_input_unit_if #(
    parameter int NUM_PORTS = 5,
    parameter int WIDTH     = `ROUTER_WIDTH
);
    logic                 in_data_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 upstream_credit;
    logic [NUM_PORTS-1:0] sw_req;
    logic [NUM_PORTS-1:0] sw_grant;
    logic [WIDTH-1:0]     head_data;

    // Master is the side that sends flits and grants (NI + switch allocator).
    modport master (
        output in_data_valid, in_data, sw_grant,
        input  upstream_credit, sw_req, head_data
    );

    modport slave (
        input  in_data_valid, in_data, sw_grant,
        output upstream_credit, sw_req, head_data
    );
endinterface

// File: rtl/router_input_unit.sv
// Leaf-router input port: credit-managed flit FIFO whose head flit is decoded
// into per-port switch requests and held until every requested port has taken it.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef ROUTER_INFO_READ
`define ROUTER_INFO_READ 4'h1
`define ROUTER_INFO_FIN_COMP 4'h2
`define ROUTER_INFO_BROADCAST 4'h3
`define ROUTER_INFO_FIN_BROADCAST 4'h4
`endif

module router_input_unit #(
    parameter int FIFO_DEPTH = `ROUTER_FIFO_DEPTH,
    parameter int NUM_PORTS  = 5,
    parameter int PORT_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    router_input_unit_if.slave    link,
    output logic                  overflow_err,
    output logic                  drop_err
);

    localparam int WIDTH  = `ROUTER_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PARENT = NUM_PORTS - 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [NUM_PORTS-1:0] served;
    logic [NUM_PORTS-1:0] route;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] served_next;
    logic [WIDTH-1:0]     head;
    logic [3:0]           head_info;
    logic                 empty;
    logic                 full;
    logic                 head_invalid;
    logic                 deq;
    logic                 wr_en;
    logic                 credit_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head      = mem[rd_ptr];
    assign head_info = head[WIDTH-1 -: 4];

    // Route decode is gated by !empty so stale storage never raises a request.
    always_comb begin
        route        = '0;
        head_invalid = 1'b0;
        if (!empty) begin
            case (head_info)
                `ROUTER_INFO_BROADCAST, `ROUTER_INFO_FIN_BROADCAST: begin
                    route          = '1;
                    route[PORT_ID] = 1'b0;
                end
                `ROUTER_INFO_READ, `ROUTER_INFO_FIN_COMP: route[PARENT] = 1'b1;
                default: head_invalid = 1'b1;
            endcase
        end
    end

    assign req         = route & ~served & {NUM_PORTS{!empty}};
    assign served_next = served | (link.sw_grant & req);
    assign deq         = !empty &&
                         (head_invalid || (route != '0 && (served_next & route) == route));
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en       = link.in_data_valid && (!full || deq);

    // NOTE: flit storage has no reset; pointers and count alone define validity,
    // so leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= link.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            served       <= '0;
            credit_q     <= 1'b0;
            overflow_err <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (deq)   rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            served       <= deq ? '0 : served_next;
            credit_q     <= deq;
            overflow_err <= overflow_err | (link.in_data_valid && full && !deq);
            drop_err     <= drop_err | (deq && head_invalid);
        end
    end

    assign link.sw_req          = req;
    assign link.head_data       = head;
    assign link.upstream_credit = credit_q;

endmodule

// File: tb/tb_router_input_unit.sv
// Self-checking bench for router_input_unit: directed scenarios on two port
// instances with a flit scoreboard on the PORT_ID=2 instance.
`ifndef ROUTER_INFO_READ
`define ROUTER_INFO_READ 4'h1
`define ROUTER_INFO_FIN_COMP 4'h2
`define ROUTER_INFO_BROADCAST 4'h3
`define ROUTER_INFO_FIN_BROADCAST 4'h4
`endif

module tb_router_input_unit;

    localparam logic [3:0] I_READ     = `ROUTER_INFO_READ;
    localparam logic [3:0] I_FIN_COMP = `ROUTER_INFO_FIN_COMP;
    localparam logic [3:0] I_BCAST    = `ROUTER_INFO_BROADCAST;
    localparam logic [3:0] I_BAD      = 4'hF;

    logic clk = 1'b0;
    logic rst;
    logic ovf0, drp0, ovf2, drp2;

    always #5 clk = ~clk;

    router_input_unit_if #(.NUM_PORTS(5), .WIDTH(36)) bus0 ();
    router_input_unit_if #(.NUM_PORTS(5), .WIDTH(36)) bus2 ();

    router_input_unit #(.FIFO_DEPTH(4), .NUM_PORTS(5), .PORT_ID(0)) dut0 (
        .clk(clk), .rst(rst), .link(bus0), .overflow_err(ovf0), .drop_err(drp0)
    );
    router_input_unit #(.FIFO_DEPTH(4), .NUM_PORTS(5), .PORT_ID(2)) dut2 (
        .clk(clk), .rst(rst), .link(bus2), .overflow_err(ovf2), .drop_err(drp2)
    );

    int checks = 0;
    int errors = 0;
    int credits = 0;
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [3:0] info, input logic [15:0] a,
                                       input logic [15:0] d);
        return {info, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr2(input logic [35:0] f);
        bus2.in_data_valid = 1'b1;
        bus2.in_data       = f;
        exp_q.push_back(f);
    endtask

    // Credit retires the oldest flit first, then the current head is compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus2.upstream_credit) begin
                credits++;
                check("sb_credit_has_flit", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus2.sw_req != '0) begin
                check("sb_req_has_flit", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("sb_head_data", bus2.head_data, exp_q[0]);
            end
        end
    end

    initial begin
        int c0;
        logic [35:0] f;
        logic [35:0] e;

        rst = 1'b1;
        bus0.in_data_valid = 1'b0; bus0.in_data = '0; bus0.sw_grant = '0;
        bus2.in_data_valid = 1'b0; bus2.in_data = '0; bus2.sw_grant = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0", bus0.sw_req, 0);
        check("rst_req2", bus2.sw_req, 0);
        check("rst_credit2", bus2.upstream_credit, 0);
        check("rst_ovf2", ovf2, 0);
        check("rst_drop2", drp2, 0);
        rst = 1'b0;
        tick();

        // READ flit on the PORT_ID=0 unit
        f = mk(I_READ, 16'h0123, 16'hBEEF);
        bus0.in_data_valid = 1'b1; bus0.in_data = f;
        tick();
        bus0.in_data_valid = 1'b0;
        check("t1_req", bus0.sw_req, 5'b10000);
        check("t1_head", bus0.head_data, f);
        check("t1_credit_early", bus0.upstream_credit, 0);
        bus0.sw_grant = 5'b10000;
        tick();
        bus0.sw_grant = '0;
        check("t1_empty", bus0.sw_req, 0);
        check("t1_credit", bus0.upstream_credit, 1);
        tick();
        check("t1_credit_once", bus0.upstream_credit, 0);

        // Broadcast on PORT_ID=0 excludes port 0; a grant on port 0 is ignored
        bus0.in_data_valid = 1'b1; bus0.in_data = mk(I_BCAST, 16'h0001, 16'h0001);
        tick();
        bus0.in_data_valid = 1'b0;
        check("t1b_req", bus0.sw_req, 5'b11110);
        bus0.sw_grant = 5'b11111;
        tick();
        bus0.sw_grant = '0;
        check("t1b_empty", bus0.sw_req, 0);
        check("t1b_credit", bus0.upstream_credit, 1);

        // Broadcast on PORT_ID=2, served over two grant cycles
        c0 = credits;
        wr2(mk(I_BCAST, 16'h0200, 16'h0002));
        tick();
        bus2.in_data_valid = 1'b0;
        check("t2_req", bus2.sw_req, 5'b11011);
        bus2.sw_grant = 5'b10001;
        tick();
        bus2.sw_grant = '0;
        check("t2_req_partial", bus2.sw_req, 5'b01010);
        check("t2_no_credit", bus2.upstream_credit, 0);
        bus2.sw_grant = 5'b01010;
        tick();
        bus2.sw_grant = '0;
        check("t2_empty", bus2.sw_req, 0);
        check("t2_credit", bus2.upstream_credit, 1);
        tick();
        check("t2_credit_once", bus2.upstream_credit, 0);
        check("t2_credits", credits - c0, 1);

        // Fill to four, then an overflow write that must be dropped
        c0 = credits;
        for (int i = 0; i < 4; i++) begin
            wr2(mk(I_READ, 16'h0300 + 16'(i), 16'h3000 + 16'(i)));
            tick();
        end
        bus2.in_data_valid = 1'b0;
        check("t3_no_credit", credits - c0, 0);
        check("t3_req", bus2.sw_req, 5'b10000);
        check("t3_ovf_before", ovf2, 0);
        bus2.in_data_valid = 1'b1; bus2.in_data = mk(I_READ, 16'h03FF, 16'hDEAD);
        tick();
        bus2.in_data_valid = 1'b0;
        check("t3_ovf", ovf2, 1);
        bus2.sw_grant = 5'b10000;
        repeat (4) tick();
        bus2.sw_grant = '0;
        check("t3_drained", bus2.sw_req, 0);
        tick();
        check("t3_credits", credits - c0, 4);

        // Reset with flits queued: everything discarded, no credits
        wr2(mk(I_READ, 16'h0700, 16'h7000));
        tick();
        wr2(mk(I_READ, 16'h0701, 16'h7001));
        tick();
        bus2.in_data_valid = 1'b0;
        c0 = credits;
        rst = 1'b1;
        #1;
        check("rst_mid_req", bus2.sw_req, 0);
        check("rst_mid_ovf", ovf2, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_credits", credits - c0, 0);
        check("rst_mid_empty", bus2.sw_req, 0);

        // Full FIFO: head completes while a new flit is written
        c0 = credits;
        for (int i = 0; i < 4; i++) begin
            wr2(mk(I_READ, 16'h0400 + 16'(i), 16'h4000 + 16'(i)));
            tick();
        end
        e = mk(I_READ, 16'h04EE, 16'h4EEE);
        bus2.sw_grant = 5'b10000;
        wr2(e);
        tick();
        bus2.in_data_valid = 1'b0;
        check("t4_no_ovf", ovf2, 0);
        check("t4_req", bus2.sw_req, 5'b10000);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("t4_new_last", bus2.head_data, e);
            tick();
        end
        bus2.sw_grant = '0;
        check("t4_drained", bus2.sw_req, 0);
        tick();
        check("t4_credits", credits - c0, 5);

        // Undefined info code is dropped without requests
        c0 = credits;
        wr2(mk(I_BAD, 16'h0500, 16'h5555));
        tick();
        check("t5_no_req", bus2.sw_req, 0);
        check("t5_drop_before", drp2, 0);
        wr2(mk(I_READ, 16'h0501, 16'h5001));
        tick();
        bus2.in_data_valid = 1'b0;
        check("t5_drop", drp2, 1);
        check("t5_credit", bus2.upstream_credit, 1);
        check("t5_next_req", bus2.sw_req, 5'b10000);
        bus2.sw_grant = 5'b10000;
        tick();
        bus2.sw_grant = '0;
        tick();
        check("t5_credits", credits - c0, 2);
        check("t5_drop_sticky", drp2, 1);

        // Back-to-back FIN_COMP stream with the parent grant held
        c0 = credits;
        bus2.sw_grant = 5'b10000;
        for (int i = 0; i < 8; i++) begin
            wr2(mk(I_FIN_COMP, 16'h0600 + 16'(i), 16'h6000 + 16'(i)));
            tick();
            check("t6_req", bus2.sw_req, 5'b10000);
            check("t6_credit", bus2.upstream_credit, 64'(i > 0));
        end
        bus2.in_data_valid = 1'b0;
        tick();
        check("t6_empty", bus2.sw_req, 0);
        tick();
        bus2.sw_grant = '0;
        check("t6_credits", credits - c0, 8);

        check("end_sb_empty", exp_q.size(), 0);
        check("end_ovf0", ovf0, 0);
        check("end_drop0", drp0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
